// File: rtl/dual_fetch_ctrl.sv
// Fetch sequencer for a 2-way superscalar front end: drives the PC pair to
// instruction memory, queues returned word pairs in order and presents the two
// oldest entries to decode. Branch redirects flush the queue and insert one
// bubble cycle before fetching from the new target.
module dual_fetch_ctrl #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [XLEN-1:0]           imem_pc,
  output logic [XLEN-1:0]           imem_pc4,
  input  logic [31:0]               imem_instr1,
  input  logic [31:0]               imem_instr2,
  input  logic                      redirect_en,
  input  logic [XLEN-1:0]           redirect_pc,
  input  logic [1:0]                issue_cnt,
  output logic [1:0]                out_valid,
  output logic [31:0]               out_instr0,
  output logic [XLEN-1:0]           out_pc0,
  output logic [31:0]               out_instr1,
  output logic [XLEN-1:0]           out_pc1,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StFetch, StBubble} state_e;

  state_e          state;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr1;
  logic [PW-1:0]   wr_ptr1;
  logic [31:0]     instr_q [QDEPTH];
  logic [XLEN-1:0] pc_q    [QDEPTH];

  logic [CW-1:0]   free_slots;
  logic            push;
  logic [1:0]      issue_clamp;
  logic [CW-1:0]   pop_n;

  // Target alignment drops the low two bits of the redirect address.
  logic            unused_rpc_lsbs;
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  // Push/pop decisions use occupancy at cycle start; freed slots are not reused same cycle.
  always_comb begin
    free_slots  = CW'(QDEPTH) - q_count;
    push        = (state == StFetch) && (free_slots >= CW'(2));
    issue_clamp = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    pop_n       = (CW'(issue_clamp) < q_count) ? CW'(issue_clamp) : q_count;
    rd_ptr1     = rd_ptr + PW'(1);
    wr_ptr1     = wr_ptr + PW'(1);
  end

  // Control FSM, fetch PC, queue pointers and occupancy; redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StFetch;
      imem_pc <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else if (redirect_en) begin
      state   <= StBubble;
      imem_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      case (state)
        StBubble: state <= StFetch;
        default:  state <= StFetch;
      endcase
      if (push) begin
        wr_ptr  <= wr_ptr1 + PW'(1);
        imem_pc <= imem_pc + XLEN'(8);
      end
      rd_ptr  <= rd_ptr + PW'(pop_n);
      q_count <= q_count + (push ? CW'(2) : CW'(0)) - pop_n;
    end
  end

  // Queue storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && !redirect_en) begin
      instr_q[wr_ptr]  <= imem_instr1;
      pc_q[wr_ptr]     <= imem_pc;
      instr_q[wr_ptr1] <= imem_instr2;
      pc_q[wr_ptr1]    <= imem_pc4;
    end
  end

  // Decode-facing view of the two oldest entries, plus the slot-1 fetch address.
  always_comb begin
    imem_pc4   = imem_pc + XLEN'(4);
    out_valid  = {q_count >= CW'(2), q_count != '0};
    out_instr0 = instr_q[rd_ptr];
    out_pc0    = pc_q[rd_ptr];
    out_instr1 = instr_q[rd_ptr1];
    out_pc1    = pc_q[rd_ptr1];
  end

endmodule
